// File: rtl/pe_dot_mult_sched_pkg.sv
// Shared types and helpers for the dot-multiplier issue sequencer.
package pe_dot_mult_sched_pkg;

  typedef struct packed {
    logic [7:0] DOT_LATENCY_DSP_MULT;
  } pe_cfg_t;

  localparam pe_cfg_t PE_CFG_DEFAULT = '{DOT_LATENCY_DSP_MULT: 8'd3};

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_DRAIN = 2'd2,
    SCHED_DONE  = 2'd3
  } pe_sched_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } pe_sched_tag_t;

  // Credit counter update: take and give together cancel; give saturates at max_crd.
  function automatic int credit_next(input int cur, input logic take, input logic give,
                                     input int max_crd);
    int nxt;
    nxt = cur;
    if (take && !give) begin
      nxt = cur - 32'sd1;
    end else if (give && !take && (cur < max_crd)) begin
      nxt = cur + 32'sd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pe_dot_mult_sched_chk.sv
// Protocol checks on the credit interface of the issue sequencer.
module pe_dot_mult_sched_chk #(
  parameter int CREDITS = 8,
  parameter int CRD_W   = 4
) (
  input logic             clock,
  input logic             reset,
  input logic             issue,
  input logic             credit_return,
  input logic [CRD_W-1:0] credits
);

  a_return_at_full: assert property (@(posedge clock) disable iff (reset)
    !(credit_return && (credits == CRD_W'(CREDITS))));

  a_issue_needs_credit: assert property (@(posedge clock) disable iff (reset)
    !(issue && (credits == '0)));

endmodule

// File: rtl/pe_dot_mult_sched_valid_pipe.sv
// Tag delay line: valid bits clear on reset; occupied reports any in-flight valid.
module pe_valid_pipe #(
  parameter int WIDTH = 2,
  parameter int DELAY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             occupied
);

  logic [DELAY-1:0] vld_r;
  logic [WIDTH-1:0] dat_r [DELAY];

  // Shift valid and tag data one stage per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_r <= '0;
      for (int i = 0; i < DELAY; i++) begin
        dat_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= in_valid;
      dat_r[0] <= in_data;
      for (int i = 1; i < DELAY; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[DELAY-1];
  assign out_data  = dat_r[DELAY-1];
  assign occupied  = |vld_r;

endmodule

// File: rtl/pe_dot_mult_sched.sv
// Issue sequencer for the packed dot multiplier: pulls operand chunks under
// downstream credit control and tags each product with valid/first/last.
module pe_dot_mult_sched
  import pe_dot_mult_sched_pkg::*;
#(
  parameter pe_cfg_t cfg        = PE_CFG_DEFAULT,
  parameter int      MAX_CHUNKS = 256,
  parameter int      CREDITS    = 8,
  parameter bit      CHECK_EN   = 1'b1,
  localparam int     CNT_W      = $clog2(MAX_CHUNKS + 1),
  localparam int     CRD_W      = $clog2(CREDITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [CNT_W-1:0] i_cmd_num_chunks,
  input  logic             i_operand_valid,
  output logic             o_operand_ready,
  output logic             o_out_valid,
  output logic             o_out_first,
  output logic             o_out_last,
  input  logic             i_credit_return,
  output logic             o_busy,
  output logic             o_done
);

  localparam int LAT = int'(cfg.DOT_LATENCY_DSP_MULT);

  pe_sched_state_t  state_r, state_s;
  logic [CNT_W-1:0] remaining_r, remaining_s;
  logic             first_pend_r, first_pend_s;
  logic [CRD_W-1:0] credits_r, credits_s;
  logic             issue_s;
  logic             pipe_occ_s;
  logic [1:0]       pipe_data_s;
  pe_sched_tag_t    tag_s;

  // Issue qualifier; reset gating keeps operands from being consumed by an aborted job.
  always_comb begin
    issue_s = 1'b0;
    if ((state_r == SCHED_RUN) && i_operand_valid && (credits_r != '0) && !reset) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state, job bookkeeping and issue tagging.
  always_comb begin
    state_s      = state_r;
    remaining_s  = remaining_r;
    first_pend_s = first_pend_r;
    tag_s        = '0;
    case (state_r)
      SCHED_IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd_num_chunks == '0) begin
            state_s = SCHED_DONE;
          end else if (i_cmd_num_chunks > CNT_W'(MAX_CHUNKS)) begin
            state_s      = SCHED_RUN;
            remaining_s  = CNT_W'(MAX_CHUNKS);
            first_pend_s = 1'b1;
          end else begin
            state_s      = SCHED_RUN;
            remaining_s  = i_cmd_num_chunks;
            first_pend_s = 1'b1;
          end
        end else begin
          state_s = SCHED_IDLE;
        end
      end
      SCHED_RUN: begin
        if (issue_s) begin
          tag_s.valid  = 1'b1;
          tag_s.first  = first_pend_r;
          tag_s.last   = (remaining_r == CNT_W'(1));
          remaining_s  = remaining_r - CNT_W'(1);
          first_pend_s = 1'b0;
          if (remaining_r == CNT_W'(1)) begin
            state_s = SCHED_DRAIN;
          end else begin
            state_s = SCHED_RUN;
          end
        end else begin
          state_s = SCHED_RUN;
        end
      end
      SCHED_DRAIN: begin
        if (!pipe_occ_s) begin
          state_s = SCHED_DONE;
        end else begin
          state_s = SCHED_DRAIN;
        end
      end
      SCHED_DONE: begin
        state_s = SCHED_IDLE;
      end
      default: begin
        state_s = SCHED_IDLE;
      end
    endcase
  end

  // Credits persist across jobs and are only restored by reset.
  always_comb begin
    credits_s = CRD_W'(credit_next(int'(credits_r), issue_s, i_credit_return, CREDITS));
  end

  // State, job counters and credit register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= SCHED_IDLE;
      remaining_r  <= '0;
      first_pend_r <= 1'b0;
      credits_r    <= CRD_W'(CREDITS);
    end else begin
      state_r      <= state_s;
      remaining_r  <= remaining_s;
      first_pend_r <= first_pend_s;
      credits_r    <= credits_s;
    end
  end

  pe_valid_pipe #(
    .WIDTH(2),
    .DELAY(LAT)
  ) u_tag_pipe (
    .clock    (clock),
    .reset    (reset),
    .in_valid (tag_s.valid),
    .in_data  ({tag_s.first, tag_s.last}),
    .out_valid(o_out_valid),
    .out_data (pipe_data_s),
    .occupied (pipe_occ_s)
  );

  generate
    if (CHECK_EN) begin : g_chk
      pe_dot_mult_sched_chk #(
        .CREDITS(CREDITS),
        .CRD_W  (CRD_W)
      ) u_chk (
        .clock        (clock),
        .reset        (reset),
        .issue        (issue_s),
        .credit_return(i_credit_return),
        .credits      (credits_r)
      );
    end
  endgenerate

  assign o_out_first     = pipe_data_s[1];
  assign o_out_last      = pipe_data_s[0];
  assign o_operand_ready = issue_s;
  assign o_cmd_ready     = (state_r == SCHED_IDLE);
  assign o_busy          = (state_r != SCHED_IDLE);
  assign o_done          = (state_r == SCHED_DONE);

endmodule
